// File: rtl/apb_bridge_pkg.sv
// Shared types for the native-bus to APB bridge: FSM state and arbiter grant.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/apb_native_bridge_if.sv
// Bundle of the native request/response channels and the APB3 master bus.
// modport master: the bridge view (takes native requests, drives APB).
// modport slave:  the environment view (native-bus master plus APB slave).
interface apb_native_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              write_req;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_ack;
  logic              write_err;
  logic              read_req;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              read_ack;
  logic              read_err;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  write_req, write_addr, write_data, read_req, read_addr,
    input  prdata, pready, pslverr,
    output write_ack, write_err, read_data, read_ack, read_err,
    output paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output write_req, write_addr, write_data, read_req, read_addr,
    output prdata, pready, pslverr,
    input  write_ack, write_err, read_data, read_ack, read_err,
    input  paddr, pwrite, psel, penable, pwdata
  );
endinterface

// File: rtl/apb_bridge_wdog.sv
// pready watchdog: counts ACCESS cycles with pready low and flags expiry on
// the wait cycle that brings the count to TIMEOUT, so the FSM leaves ACCESS
// on that same edge. Only instantiated when APB_BRIDGE_TIMEOUT_EN is defined.
module apb_bridge_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // Wait-cycle counter, cleared on the way into ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = count_en && (count_reg == LAST_WAIT);
endmodule

// File: rtl/apb_native_bridge.sv
// Native-bus to APB3 master bridge with round-robin write/read arbitration.
// Optional pready watchdog compiled in with APB_BRIDGE_TIMEOUT_EN.
module apb_native_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic               pclk,
  input logic               presetn,
  apb_native_bridge_if.master bus
);
  apb_state_t        state_reg, state_next;
  grant_t            last_grant_reg, grant_pick;
  logic [ADDR_W-1:0] paddr_reg;
  logic              pwrite_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic [DATA_W-1:0] read_data_reg;
  logic              err_reg;
  logic              expired;
  logic              any_req;
  logic              done;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("apb_native_bridge: TIMEOUT must be at least 1");
  end

  assign any_req = bus.write_req | bus.read_req;
  assign done    = (state_reg == DONE);

`ifdef APB_BRIDGE_TIMEOUT_EN
  apb_bridge_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .pclk     (pclk),
    .presetn  (presetn),
    .clear    (state_reg == SETUP),
    .count_en ((state_reg == ACCESS) && !bus.pready),
    .expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Round-robin pick: a lone request wins, a tie goes to the channel not served last.
  always_comb begin
    grant_pick = GRANT_RD;
    if (bus.write_req && bus.read_req) begin
      grant_pick = (last_grant_reg == GRANT_RD) ? GRANT_WR : GRANT_RD;
    end else if (bus.write_req) begin
      grant_pick = GRANT_WR;
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; pready takes priority over a simultaneous watchdog expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (bus.pready || expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer capture in IDLE and response capture at the end of ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_grant_reg <= GRANT_RD;
      paddr_reg      <= '0;
      pwrite_reg     <= 1'b0;
      pwdata_reg     <= '0;
      read_data_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (state_reg == IDLE && any_req) begin
        last_grant_reg <= grant_pick;
        pwrite_reg     <= (grant_pick == GRANT_WR);
        if (grant_pick == GRANT_WR) begin
          paddr_reg  <= bus.write_addr;
          pwdata_reg <= bus.write_data;
        end else begin
          paddr_reg  <= bus.read_addr;
        end
      end
      if (state_reg == ACCESS) begin
        if (bus.pready) begin
          err_reg <= bus.pslverr;
          if (!pwrite_reg) read_data_reg <= bus.prdata;
        end else if (expired) begin
          err_reg <= 1'b1;
          if (!pwrite_reg) read_data_reg <= '1;
        end
      end
    end
  end

  // Outputs decoded from the state; acks and error flags only in DONE.
  always_comb begin
    bus.psel      = (state_reg == SETUP) || (state_reg == ACCESS);
    bus.penable   = (state_reg == ACCESS);
    bus.write_ack = done && pwrite_reg;
    bus.read_ack  = done && !pwrite_reg;
    bus.write_err = done && pwrite_reg && err_reg;
    bus.read_err  = done && !pwrite_reg && err_reg;
    bus.paddr     = paddr_reg;
    bus.pwrite    = pwrite_reg;
    bus.pwdata    = pwdata_reg;
    bus.read_data = read_data_reg;
  end
endmodule

// File: tb/tb_apb_native_bridge.sv
// Self-checking bench for apb_native_bridge. Watchdog scenarios run only when
// APB_BRIDGE_TIMEOUT_EN is defined.
module tb_apb_native_bridge;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb_native_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_native_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // APB slave: pready rises after wait_cfg ACCESS cycles with pready low.
  int           wait_cfg;
  logic         err_cfg;
  logic [DW-1:0] rdata_cfg;
  int           acc_cnt = 0;

  always @(posedge pclk) begin
    if (!bus.penable) acc_cnt <= 0;
    else if (!bus.pready) acc_cnt <= acc_cnt + 1;
  end
  assign bus.pready  = bus.penable && (acc_cnt >= wait_cfg);
  assign bus.prdata  = rdata_cfg;
  assign bus.pslverr = bus.pready && err_cfg;

  // Reference model: last served channel and the value read_data must show.
  bit            last_wr;
  logic [DW-1:0] exp_rd;

  function automatic bit pick_wr(input bit wr, input bit rd);
    if (wr && rd) return !last_wr;
    return wr;
  endfunction

  // Follows one transfer from the edge that samples it (after `extra` idle
  // edges) to its ack; ack expected 2 + waits edges after sampling.
  task automatic wait_ack(input bit is_wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int waits,
                          input int extra, input bit err,
                          input logic [DW-1:0] rdata, input bit hold,
                          input string name);
    int n;
    int final_n;
    bit got;
    bit exp_psel;
    bit exp_pen;
    final_n = extra + 2 + waits;
    n = 0;
    got = 0;
    @(posedge pclk);
    while (!got && n <= final_n + 3) begin
      @(negedge pclk);
      exp_psel = (n >= extra) && (n < final_n);
      exp_pen  = (n > extra) && (n < final_n);
      checks++;
      if (bus.psel !== exp_psel || bus.penable !== exp_pen) begin
        failures++;
        $display("FAIL %s phase cyc=%0d psel,penable got=%b%b exp=%b%b",
                 name, n, bus.psel, bus.penable, exp_psel, exp_pen);
      end
      if (bus.psel === 1'b1) begin
        checks++;
        if (bus.paddr !== addr || bus.pwrite !== is_wr ||
            (is_wr && bus.pwdata !== wdata)) begin
          failures++;
          $display("FAIL %s apb_bus paddr=%h pwrite=%b pwdata=%h exp %h %b %h",
                   name, bus.paddr, bus.pwrite, bus.pwdata, addr, is_wr, wdata);
        end
      end
      if (bus.write_ack === 1'b1 || bus.read_ack === 1'b1) begin
        got = 1;
        checks++;
        if (n != final_n) begin
          failures++;
          $display("FAIL %s latency got=%0d exp=%0d", name, n, final_n);
        end
        checks++;
        if (bus.write_ack !== is_wr || bus.read_ack !== !is_wr) begin
          failures++;
          $display("FAIL %s ack_channel wr_ack=%b rd_ack=%b exp_wr=%b",
                   name, bus.write_ack, bus.read_ack, is_wr);
        end
        checks++;
        if ({bus.write_err, bus.read_err} !== (is_wr ? {err, 1'b0} : {1'b0, err})) begin
          failures++;
          $display("FAIL %s err got wr=%b rd=%b exp=%b", name,
                   bus.write_err, bus.read_err, err);
        end
        if (!is_wr) exp_rd = rdata;
        checks++;
        if (bus.read_data !== exp_rd) begin
          failures++;
          $display("FAIL %s read_data got=%h exp=%h", name, bus.read_data, exp_rd);
        end
        last_wr = is_wr;
        if (!hold) begin
          if (is_wr) bus.write_req = 1'b0;
          else bus.read_req = 1'b0;
        end
        $display("txn %s %s addr=%h wdata=%h rdata=%h err=%b lat=%0d", name,
                 is_wr ? "WR" : "RD", addr, wdata, bus.read_data, err, n);
      end else begin
        checks++;
        if (bus.read_data !== exp_rd) begin
          failures++;
          $display("FAIL %s read_data_hold got=%h exp=%h", name, bus.read_data, exp_rd);
        end
        @(posedge pclk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s no_ack got=none exp=ack within %0d cycles", name, final_n);
    end
  endtask

  task automatic set_slave(input int w, input logic e, input logic [DW-1:0] r);
    wait_cfg  = w;
    err_cfg   = e;
    rdata_cfg = r;
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    last_wr = 1'b0;
    exp_rd  = '0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({bus.psel, bus.penable, bus.write_ack, bus.read_ack, bus.write_err,
         bus.read_err, bus.pwrite} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.psel, bus.penable, bus.write_ack,
               bus.read_ack, bus.write_err, bus.read_err, bus.pwrite});
    end
    checks++;
    if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.read_data !== '0) begin
      failures++;
      $display("FAIL reset_data paddr=%h pwdata=%h read_data=%h exp=0",
               bus.paddr, bus.pwdata, bus.read_data);
    end
    presetn = 1'b1;
    last_wr = 1'b0;
    exp_rd  = '0;
    @(negedge pclk);
    checks++;
    if (bus.psel !== 1'b0 || bus.write_ack !== 1'b0 || bus.read_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle psel=%b acks=%b%b exp=0", bus.psel,
               bus.write_ack, bus.read_ack);
    end
    $display("txn reset done");
  endtask

  task automatic test_write_zero_wait();
    @(negedge pclk);
    set_slave(0, 1'b0, 8'h00);
    bus.write_addr = 8'hCC;
    bus.write_data = 8'hAC;
    bus.write_req  = 1'b1;
    wait_ack(1'b1, 8'hCC, 8'hAC, 0, 0, 1'b0, 8'h00, 1'b0, "write_zero_wait");
  endtask

  task automatic test_read_waits();
    @(negedge pclk);
    set_slave(3, 1'b0, 8'hFF);
    bus.read_addr = 8'h55;
    bus.read_req  = 1'b1;
    wait_ack(1'b0, 8'h55, 8'h00, 3, 0, 1'b0, 8'hFF, 1'b0, "read_waits");
    rdata_cfg = 8'h12;
    repeat (3) begin
      @(negedge pclk);
      checks++;
      if (bus.read_data !== 8'hFF) begin
        failures++;
        $display("FAIL read_hold got=%h exp=ff", bus.read_data);
      end
    end
  endtask

  task automatic test_slave_error();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom);
    d = DW'($urandom);
    @(negedge pclk);
    set_slave(1, 1'b1, 8'h00);
    bus.write_addr = a;
    bus.write_data = d;
    bus.write_req  = 1'b1;
    wait_ack(1'b1, a, d, 1, 0, 1'b1, 8'h00, 1'b0, "slave_err");
    @(negedge pclk);
    set_slave(0, 1'b0, 8'h00);
    bus.write_req = 1'b1;
    wait_ack(1'b1, a, d, 0, 0, 1'b0, 8'h00, 1'b0, "after_err");
  endtask

  task automatic test_tie();
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd;
    bit w;
    int wt;
    logic e;
    apply_reset();
    wa = AW'($urandom);
    ra = AW'($urandom);
    wd = DW'($urandom);
    bus.write_addr = wa;
    bus.write_data = wd;
    bus.read_addr  = ra;
    for (int k = 0; k < 4; k++) begin
      w  = pick_wr(1'b1, 1'b1);
      wt = $urandom_range(0, 2);
      e  = 1'($urandom_range(0, 1));
      rd = DW'($urandom);
      set_slave(wt, e, rd);
      if (k == 0) begin
        bus.write_req = 1'b1;
        bus.read_req  = 1'b1;
      end
      wait_ack(w, w ? wa : ra, wd, wt, (k == 0) ? 0 : 1, e, rd, 1'b1, "tie");
      checks++;
      if (w !== ((k % 2) == 0)) begin
        failures++;
        $display("FAIL tie_order k=%0d got_wr=%b exp_wr=%b", k, w, (k % 2) == 0);
      end
    end
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
  endtask

  task automatic test_random();
    int mode;
    bit wr, rq, first;
    int wt;
    logic e;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd;
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      mode = $urandom_range(0, 2);
      wr = (mode != 1);
      rq = (mode != 0);
      wa = AW'($urandom);
      ra = AW'($urandom);
      wd = DW'($urandom);
      rd = DW'($urandom);
      wt = $urandom_range(0, 3);
      e  = 1'($urandom_range(0, 1));
      set_slave(wt, e, rd);
      bus.write_addr = wa;
      bus.write_data = wd;
      bus.read_addr  = ra;
      bus.write_req  = wr;
      bus.read_req   = rq;
      first = pick_wr(wr, rq);
      wait_ack(first, first ? wa : ra, wd, wt, 0, e, rd, 1'b0, "random");
      if (wr && rq) begin
        rd = DW'($urandom);
        wt = $urandom_range(0, 3);
        e  = 1'($urandom_range(0, 1));
        set_slave(wt, e, rd);
        wait_ack(!first, first ? ra : wa, wd, wt, 1, e, rd, 1'b0, "back_to_back");
      end
    end
  endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
  task automatic test_watchdog();
    @(negedge pclk);
    set_slave(1000, 1'b0, 8'h3C);
    bus.read_addr = 8'h77;
    bus.read_req  = 1'b1;
    wait_ack(1'b0, 8'h77, 8'h00, TO - 1, 0, 1'b1, 8'hFF, 1'b0, "watchdog");
    @(negedge pclk);
    set_slave(TO - 1, 1'b0, 8'h5A);
    bus.read_req = 1'b1;
    wait_ack(1'b0, 8'h77, 8'h00, TO - 1, 0, 1'b0, 8'h5A, 1'b0, "ready_vs_wdog");
  endtask
`endif

  task automatic test_reset_mid_access();
    bit seen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    seen = 0;
    @(negedge pclk);
    set_slave(50, 1'b0, 8'h99);
    bus.read_addr = 8'h21;
    bus.read_req  = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge pclk);
      if (bus.penable === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid reach_access got=no exp=penable");
    end
    presetn = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.write_ack, bus.read_ack} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid async_drop got=%b exp=0000",
               {bus.psel, bus.penable, bus.write_ack, bus.read_ack});
    end
    bus.read_req = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    last_wr = 1'b0;
    exp_rd  = '0;
    repeat (6) begin
      @(negedge pclk);
      checks++;
      if ({bus.psel, bus.penable, bus.write_ack, bus.read_ack} !== 4'b0 ||
          bus.read_data !== '0) begin
        failures++;
        $display("FAIL reset_mid quiet got=%b read_data=%h exp=0000 00",
                 {bus.psel, bus.penable, bus.write_ack, bus.read_ack}, bus.read_data);
      end
    end
    a = AW'($urandom);
    d = DW'($urandom);
    set_slave(0, 1'b0, 8'h00);
    bus.write_addr = a;
    bus.write_data = d;
    bus.write_req  = 1'b1;
    wait_ack(1'b1, a, d, 0, 0, 1'b0, 8'h00, 1'b0, "after_reset");
  endtask

  initial begin
    set_slave(0, 1'b0, 8'h00);
    bus.write_req  = 1'b0;
    bus.read_req   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.read_addr  = '0;
    last_wr = 1'b0;
    exp_rd  = '0;
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_tie();
    test_random();
`ifdef APB_BRIDGE_TIMEOUT_EN
    test_watchdog();
`endif
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_native_bridge.md
# apb_native_bridge

Parametrised native-bus-to-APB master bridge for the native-bus/APB memory path. It accepts independent write and read request channels from a native-bus master and arbitrates them round-robin. Each request becomes one APB3 transfer (SETUP/ACCESS) towards an APB slave, such as the memory front-end. It adds error reporting (`pslverr`) and an optional `pready` watchdog over the fixed 8-bit converter generation.

## Interface
- `ADDR_W`, 8, address width of the native bus and `paddr`.
- `DATA_W`, 8, data width of `write_data`, `read_data`, `pwdata` and `prdata`.
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready` low before abort; must be ≥ 1; used only with the watchdog compiled in.

Ports:
- `pclk` in 1: single clock; all logic is rising-edge.
- `presetn` in 1: asynchronous, active-low reset.
- `write_req` in 1: write request, level, held until `write_ack`.
- `write_addr` in ADDR_W: write address.
- `write_data` in DATA_W: write data.
- `write_ack` out 1: one-cycle write completion pulse.
- `write_err` out 1: write failed; valid only while `write_ack` = 1.
- `read_req` in 1: read request, level, held until `read_ack`.
- `read_addr` in ADDR_W: read address.
- `read_data` out DATA_W: read result; updated on read completion, held otherwise.
- `read_ack` out 1: one-cycle read completion pulse.
- `read_err` out 1: read failed; valid only while `read_ack` = 1.
- `paddr` out ADDR_W, `pwrite` out 1, `psel` out 1, `penable` out 1, `pwdata` out DATA_W: APB master outputs.
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB slave responses.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. Reset state is IDLE.
- **IDLE:**
  - If either request is high, capture the winner's address and data (and `pwrite`) into registers, then go to SETUP.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - A single request always wins.
  - If both requests are high, the grant goes to the channel not served last.
  - The `last_grant` register resets to "read", so write wins the first tie.
- **SETUP:** `psel` = 1, `penable` = 0. Always go to ACCESS next cycle.
- **ACCESS:** `psel` = 1, `penable` = 1.
  - `pready` = 1: sample `prdata` (reads) and `pslverr`, then go to DONE.
  - `pready` = 0: stay in ACCESS.
- **DONE:**
  - `psel` and `penable` are 0.
  - Exactly one of `write_ack`/`read_ack` is 1; its err flag equals the sampled `pslverr`.
  - Go to IDLE next cycle.
- **Master rule:** deassert the request during the ack cycle. A request still high in IDLE starts a new transfer.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the end of ACCESS and hold their last values otherwise.
- A read that ends with `pslverr` = 1 still updates `read_data` with `prdata`.

## Timing
- Reset values: every output is 0 (`paddr`, `pwdata` and `read_data` are all zeros). Asserting `presetn` low mid-transfer returns the FSM to IDLE immediately, drops `psel`/`penable` asynchronously, and issues no ack.
- Zero-wait transfer, with the request sampled high at edge E0:
  - `psel` = 1 after E0.
  - `penable` = 1 after E1.
  - `pready` is sampled at E2.
  - Ack is high between E2 and E3.
  - IDLE after E3.
- Each wait state (`pready` = 0 at a sampling edge) adds one cycle.
- Back-to-back transfers: the minimum spacing between acks is 4 cycles.
- Simultaneous `pready` = 1 and watchdog expiry in the same cycle: `pready` wins and the transfer completes normally.

## Configuration
- Macro: `APB_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - A counter of width $clog2(TIMEOUT+1) clears on entry to ACCESS and increments on each ACCESS cycle with `pready` = 0.
  - When the count reaches TIMEOUT, the bridge goes to DONE with err = 1.
  - A read aborted this way loads `read_data` with all ones.
- **Not defined:** no counter is present; ACCESS waits indefinitely for `pready`, and `TIMEOUT` is ignored.

## Structure
- Package `apb_bridge_pkg` holds:
  - the state enum `apb_state_t` (IDLE, SETUP, ACCESS, DONE);
  - the grant enum `grant_t` (GRANT_WR, GRANT_RD).
- Sub-module `apb_bridge_wdog` holds the watchdog counter:
  - inputs: `pclk`, `presetn`, `clear`, `count_en`;
  - output: `expired`;
  - parameter: `TIMEOUT`;
  - instantiated only under `APB_BRIDGE_TIMEOUT_EN`.

## Test plan
- **Write, zero wait:** write_req with addr 0xCC, data 0xAC, slave with `pready` tied high → `paddr` = 0xCC and `pwdata` = 0xAC through SETUP/ACCESS; `write_ack` high 3 cycles after the request is sampled; `write_err` = 0.
- **Read with waits:** read addr 0x55, slave holds `pready` low for 3 cycles, `prdata` = 0xFF → `read_ack` 6 cycles after the request is sampled; `read_data` = 0xFF and holds afterwards.
- **Tie arbitration:** both requests held continuously after reset → acks alternate write, read, write, read.
- **Slave error:** write with `pslverr` = 1 at the completing cycle → `write_ack` = 1 with `write_err` = 1; the next transfer has err = 0.
- **Watchdog** (`APB_BRIDGE_TIMEOUT_EN`, TIMEOUT = 4): read with `pready` stuck low → `psel` drops after 4 ACCESS cycles; `read_ack` with `read_err` = 1; `read_data` = 0xFF.
- **Reset mid-ACCESS:** assert `presetn` low during a pending read → `psel`, `penable` and acks go to 0 immediately; no ack after release; the FSM restarts in IDLE.
